// File: rtl/fetch_stage.sv
// Instruction-fetch stage: program counter, IF/ID register, branch/halt resolution.
// Optional perf counters (fetch/flush/stall) enabled by defining FETCH_PERF_CNT_EN.
module fetch_stage #(
    parameter int                   PC_W      = 8,
    parameter int                   INSTR_W   = 9,
    parameter logic [INSTR_W-1:0]   NOP_INSTR = 9'b111_000000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    input  logic               halt,
    input  logic               branch,
    input  logic               takeit,
    input  logic               direct_flag,
    input  logic [PC_W-1:0]    branch_target,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [INSTR_W-1:0] instruction,
    output logic [PC_W-1:0]    if_pc,
    output logic               if_valid,
    output logic               halted
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0]        fetch_cnt,
    output logic [15:0]        flush_cnt,
    output logic [15:0]        stall_cnt
`endif
);

    typedef enum logic [0:0] {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;
    logic [PC_W-1:0]    if_pc_q, if_pc_d;
    logic               if_valid_q, if_valid_d;
    logic               halted_q, halted_d;
    logic               ev_fetch_s, ev_flush_s, ev_stall_s;
    logic [PC_W-1:0]    target_s;
    logic [PC_W-1:0]    rel_off_s;

    // Branch target: direct register value or IF/ID pc plus sign-extended 4-bit offset
    always_comb begin
        rel_off_s = {{(PC_W-4){instr_q[3]}}, instr_q[3:0]};
        if (direct_flag) begin
            target_s = branch_target;
        end else begin
            target_s = if_pc_q + rel_off_s;
        end
    end

    // Next-state logic; priority in RUN is stall > halt > redirect > advance
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        if_pc_d    = if_pc_q;
        if_valid_d = if_valid_q;
        halted_d   = halted_q;
        ev_fetch_s = 1'b0;
        ev_flush_s = 1'b0;
        ev_stall_s = 1'b0;
        case (state_q)
            RUN: begin
                if (stall) begin
                    ev_stall_s = 1'b1;
                end else if (halt && if_valid_q) begin
                    state_d    = HALTED;
                    instr_d    = NOP_INSTR;
                    if_valid_d = 1'b0;
                    halted_d   = 1'b1;
                end else if (branch && takeit && if_valid_q) begin
                    pc_d       = target_s;
                    instr_d    = NOP_INSTR;
                    if_valid_d = 1'b0;
                    if_pc_d    = pc_q;
                    ev_flush_s = 1'b1;
                end else begin
                    instr_d    = imem_data;
                    if_pc_d    = pc_q;
                    if_valid_d = 1'b1;
                    pc_d       = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
                    ev_fetch_s = 1'b1;
                end
            end
            HALTED: begin
                halted_d = 1'b1;
            end
            default: begin
                // Illegal encoding: fall back to a safe halted-free RUN with a bubble
                state_d    = RUN;
                instr_d    = NOP_INSTR;
                if_valid_d = 1'b0;
                halted_d   = 1'b0;
            end
        endcase
    end

    // Pipeline and state registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= RUN;
            pc_q       <= {PC_W{1'b0}};
            instr_q    <= NOP_INSTR;
            if_pc_q    <= {PC_W{1'b0}};
            if_valid_q <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            if_pc_q    <= if_pc_d;
            if_valid_q <= if_valid_d;
            halted_q   <= halted_d;
        end
    end

    assign imem_addr   = pc_q;
    assign instruction = instr_q;
    assign if_pc       = if_pc_q;
    assign if_valid    = if_valid_q;
    assign halted      = halted_q;

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] fetch_cnt_q, flush_cnt_q, stall_cnt_q;

    // Saturating event counters; events only fire in RUN so they freeze when halted
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_cnt_q <= 16'd0;
            flush_cnt_q <= 16'd0;
            stall_cnt_q <= 16'd0;
        end else begin
            if (ev_fetch_s && (fetch_cnt_q != 16'hFFFF)) begin
                fetch_cnt_q <= fetch_cnt_q + 16'd1;
            end else begin
                fetch_cnt_q <= fetch_cnt_q;
            end
            if (ev_flush_s && (flush_cnt_q != 16'hFFFF)) begin
                flush_cnt_q <= flush_cnt_q + 16'd1;
            end else begin
                flush_cnt_q <= flush_cnt_q;
            end
            if (ev_stall_s && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end else begin
                stall_cnt_q <= stall_cnt_q;
            end
        end
    end

    assign fetch_cnt = fetch_cnt_q;
    assign flush_cnt = flush_cnt_q;
    assign stall_cnt = stall_cnt_q;
`else
    logic unused_ev_s;
    assign unused_ev_s = ev_fetch_s ^ ev_flush_s ^ ev_stall_s;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed test-plan sequences plus random stimulus
// checked against a behavioural reference model.
module tb_fetch_stage;

    localparam logic [8:0] NOP = 9'b111_000000;

    logic       clk = 1'b0;
    logic       rst_n, stall, halt, branch, takeit, direct_flag;
    logic [7:0] branch_target, imem_addr, if_pc;
    logic [8:0] imem_data, instruction;
    logic       if_valid, halted;
    logic [8:0] mem [256];
`ifdef FETCH_PERF_CNT_EN
    logic [15:0] fetch_cnt, flush_cnt, stall_cnt;
`endif

    typedef struct packed {
        logic [7:0]  pc;
        logic [8:0]  instr;
        logic [7:0]  if_pc;
        logic        valid;
        logic        halted;
        logic [15:0] fc;
        logic [15:0] flc;
        logic [15:0] sc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   first_step = 1'b1;

    // Reference model state
    logic [7:0]  m_pc, m_if_pc;
    logic [8:0]  m_instr;
    logic        m_valid, m_halted;
    int          m_fc, m_flc, m_sc;

    always #5 clk = ~clk;

    assign imem_data = mem[imem_addr];

    fetch_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .halt          (halt),
        .branch        (branch),
        .takeit        (takeit),
        .direct_flag   (direct_flag),
        .branch_target (branch_target),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .instruction   (instruction),
        .if_pc         (if_pc),
        .if_valid      (if_valid),
        .halted        (halted)
`ifdef FETCH_PERF_CNT_EN
        ,
        .fetch_cnt     (fetch_cnt),
        .flush_cnt     (flush_cnt),
        .stall_cnt     (stall_cnt)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Apply one cycle of inputs, advance the model by the spec rules, push expectation
    task automatic step(input bit r, input bit s, input bit h, input bit b,
                        input bit t, input bit d, input logic [7:0] bt);
        logic [3:0] off4;
        logic [7:0] tgt;
        int         off;
        exp_t       e;
        if (!first_step) @(negedge clk);
        first_step = 1'b0;
        rst_n = r; stall = s; halt = h; branch = b; takeit = t;
        direct_flag = d; branch_target = bt;
        if (!r) begin
            m_pc = 8'd0; m_instr = NOP; m_if_pc = 8'd0; m_valid = 1'b0; m_halted = 1'b0;
            m_fc = 0; m_flc = 0; m_sc = 0;
        end else if (m_halted) begin
            // everything frozen
        end else if (s) begin
            if (m_sc < 65535) m_sc++;
        end else if (h && m_valid) begin
            m_halted = 1'b1; m_instr = NOP; m_valid = 1'b0;
        end else if (b && t && m_valid) begin
            off4 = m_instr[3:0];
            off = int'($signed(off4));
            tgt = d ? bt : 8'((int'(m_if_pc) + off + 256) % 256);
            m_if_pc = m_pc;
            m_pc = tgt;
            m_instr = NOP; m_valid = 1'b0;
            if (m_flc < 65535) m_flc++;
        end else begin
            m_instr = mem[m_pc]; m_if_pc = m_pc; m_valid = 1'b1;
            m_pc = 8'((int'(m_pc) + 1) % 256);
            if (m_fc < 65535) m_fc++;
        end
        e.pc = m_pc; e.instr = m_instr; e.if_pc = m_if_pc; e.valid = m_valid;
        e.halted = m_halted; e.fc = 16'(m_fc); e.flc = 16'(m_flc); e.sc = 16'(m_sc);
        exp_q.push_back(e);
    endtask

    // Monitor: pop one expectation per posedge and compare shortly after the edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("imem_addr",   32'(imem_addr),   32'(e.pc));
                chk("instruction", 32'(instruction), 32'(e.instr));
                chk("if_pc",       32'(if_pc),       32'(e.if_pc));
                chk("if_valid",    32'(if_valid),    32'(e.valid));
                chk("halted",      32'(halted),      32'(e.halted));
`ifdef FETCH_PERF_CNT_EN
                chk("fetch_cnt",   32'(fetch_cnt),   32'(e.fc));
                chk("flush_cnt",   32'(flush_cnt),   32'(e.flc));
                chk("stall_cnt",   32'(stall_cnt),   32'(e.sc));
`endif
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 9'($urandom);
        mem[5] = 9'b000_001101;

        // Reset, then free run up to if_pc=5
        step(0, 0, 0, 0, 0, 0, 8'd0);
        step(0, 0, 0, 0, 0, 0, 8'd0);
        for (int i = 0; i < 6; i++) step(1, 0, 0, 0, 0, 0, 8'd0);
        // Relative taken branch: 5 + (-3) = 2
        step(1, 0, 0, 1, 1, 0, 8'd0);
        step(1, 0, 0, 0, 0, 0, 8'd0);
        step(1, 0, 0, 0, 0, 0, 8'd0);
        // Direct branch held off by two stall cycles
        step(1, 1, 0, 1, 1, 1, 8'hF0);
        step(1, 1, 0, 1, 1, 1, 8'hF0);
        step(1, 0, 0, 1, 1, 1, 8'hF0);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 8'd0);
        // Untaken branch behaves as advance
        step(1, 0, 0, 1, 0, 1, 8'h10);
        // Halt, then branches and stalls are ignored, then reset
        step(1, 0, 1, 0, 0, 0, 8'd0);
        for (int i = 0; i < 3; i++) step(1, i[0], 0, 1, 1, 1, 8'h40);
        step(0, 0, 0, 0, 0, 0, 8'd0);
        step(1, 0, 0, 0, 0, 0, 8'd0);
        step(1, 0, 0, 0, 0, 0, 8'd0);
        // PC wrap via direct branch to FF
        step(1, 0, 0, 1, 1, 1, 8'hFF);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 0, 0, 8'd0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom % 64) != 0, ($urandom % 4) == 0, ($urandom % 40) == 0,
                 ($urandom % 3) == 0, ($urandom % 2) == 0, ($urandom % 2) == 0,
                 8'($urandom));
        end
        step(1, 0, 0, 0, 0, 0, 8'd0);
        @(negedge clk);
        @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the 9-bit pipelined CPU, directly upstream of the decode/control stage. It owns the program counter and drives the instruction-memory address. It holds the IF/ID pipeline register that feeds `instruction` to control. It also resolves branches and halt decoded from the IF/ID instruction, squashing the wrong-path fetch with a NOP bubble.

## Interface
Parameters:
- PC_W, 8, program counter and instruction-memory address width
- INSTR_W, 9, instruction width; fixed at 9 for this ISA
- NOP_INSTR, 9'b111_000000, bubble encoding (opcode 111, no register/memory writes)

Ports:
- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  synchronous, active-low reset
- stall  in  1  hazard hold from downstream; freezes PC and IF/ID
- halt  in  1  control's halt for the IF/ID instruction
- branch  in  1  control's branch flag for the IF/ID instruction
- takeit  in  1  branch condition met (from control)
- direct_flag  in  1  1 = direct target, 0 = PC-relative offset
- branch_target  in  PC_W  register-file value used as the direct target
- imem_addr  out  PC_W  instruction-memory read address; memory read is combinational
- imem_data  in  INSTR_W  instruction at imem_addr, same cycle
- instruction  out  INSTR_W  IF/ID instruction register, drives control
- if_pc  out  PC_W  PC of the instruction in IF/ID
- if_valid  out  1  IF/ID holds a real fetched instruction
- halted  out  1  fetch permanently stopped

## Operation
- States: RUN, HALTED. Reset enters RUN.
- Reset values while rst_n=0, sampled at posedge: pc=0, instruction=NOP_INSTR, if_pc=0, if_valid=0, halted=0, state=RUN. imem_addr follows pc combinationally, so it is 0.
- imem_addr = pc at all times.
- Per-cycle priority in RUN is stall > halt > redirect > advance.
  - stall=1: pc, instruction, if_pc and if_valid all hold. halt and branch are ignored this cycle; they are re-evaluated once stall drops.
  - halt=1 and if_valid=1: go to HALTED; instruction<=NOP_INSTR, if_valid<=0, halted<=1, pc holds.
  - redirect, when branch & takeit & if_valid: pc<=target; instruction<=NOP_INSTR; if_valid<=0; if_pc<=pc.
  - advance: instruction<=imem_data; if_pc<=pc; if_valid<=1; pc<=pc+1.
- Branch target computation:
  - direct_flag=1: target = branch_target.
  - direct_flag=0: target = if_pc + sign-extended instruction[3:0], range -8..+7.
- All PC arithmetic is modulo 2^PC_W, so pc+1 at max wraps to 0.
- An untaken branch (branch=1, takeit=0) behaves as advance.
- HALTED: all registers hold, halted=1, and stall/branch are ignored. Only rst_n=0 exits.
- Inputs with if_valid=0 (bubble) never cause halt or redirect.

## Timing
- Fetch-to-decode latency is 1 cycle: the word at imem_addr in cycle N appears on `instruction` in cycle N+1.
- A taken branch costs 1 bubble:
  - branch in IF/ID at cycle N;
  - NOP in IF/ID at cycle N+1, with imem_addr=target;
  - target instruction in IF/ID at cycle N+2.
- Halt: halted rises the cycle after halt is sampled with if_valid=1.
- Reset mid-operation, including in HALTED or mid-stall: state returns to RUN at the next posedge with rst_n=0. The first real instruction (addr 0) appears in IF/ID 1 cycle after rst_n rises.
- Stall released in cycle N: the pending branch or halt acts at the posedge ending cycle N.

## Configuration
- FETCH_PERF_CNT_EN defined adds three outputs:
  - fetch_cnt [15:0]: counts advance events.
  - flush_cnt [15:0]: counts taken redirects.
  - stall_cnt [15:0]: counts stalled RUN cycles.
  - All three reset to 0, saturate at 16'hFFFF, and freeze in HALTED.
- Undefined: these ports and counters do not exist. Core behaviour is identical either way.

## Test plan
- Reset then free-run over imem[0..3]=A,B,C,D. Required: imem_addr 0,1,2,3; instruction NOP,A,B,C; if_pc 0,0,1,2; if_valid 0,1,1,1.
- Relative taken branch: at if_pc=5, instruction[3:0]=4'b1101, branch=takeit=1, direct_flag=0. Required: next imem_addr=2, next instruction=NOP with if_valid=0, then imem[2].
- Direct taken branch with stall: branch_target=8'hF0, stall=1 for 2 cycles, then 0. Required: pc held through the stall, redirect to F0 the cycle stall drops, exactly one bubble.
- Halt: halt=1 on a valid instruction. Required: halted=1 next cycle, imem_addr frozen; a later branch=takeit=1 has no effect. Then rst_n=0 for one posedge: pc=0, halted=0.
- PC wrap: start at pc=8'hFF with no stall. Required: imem_addr goes FF then 00, and if_pc=FF for the instruction fetched at FF.
- With FETCH_PERF_CNT_EN: 10 advances, 2 taken branches, 3 stall cycles. Required: fetch_cnt=10, flush_cnt=2, stall_cnt=3.
